// File: rtl/snake_body_ctrl.sv
// Sequencer for the free-running snake-body ring: closes sr_out->sr_in,
// tracks head slot and length, fills after reset, schedules step and scan.
module snake_body_ctrl #(
  parameter int WIDTH    = 2,
  parameter int DEPTH    = 234,
  parameter int INIT_LEN = 3,
  parameter int INIT_DIR = 0,
  localparam int PH_W    = $clog2(DEPTH),
  localparam int LEN_W   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] sr_in,
  input  logic [WIDTH-1:0] sr_out,
  input  logic             step_valid,
  output logic             step_ready,
  input  logic [WIDTH-1:0] step_dir,
  input  logic             step_grow,
  output logic             step_done,
  input  logic             scan_valid,
  output logic             scan_ready,
  output logic             seg_valid,
  output logic [WIDTH-1:0] seg_dir,
  output logic [LEN_W-1:0] seg_idx,
  output logic             seg_last,
  output logic [LEN_W-1:0] length,
  output logic             full,
  output logic             busy
);

  localparam logic [PH_W-1:0]  PH_MAX  = PH_W'(DEPTH - 1);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(DEPTH);
  localparam logic [LEN_W-1:0] LEN_RST = LEN_W'(INIT_LEN);
  localparam logic [WIDTH-1:0] DIR_RST = WIDTH'(INIT_DIR);

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_WSTEP,
    S_DONE,
    S_WSCAN,
    S_SCAN
  } state_e;

  state_e           state_q, state_d;
  logic [PH_W-1:0]  phase_q, phase_d;
  logic [PH_W-1:0]  head_q, head_d;
  logic [PH_W-1:0]  head_m1;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] dir_q, dir_d;
  logic             grow_q, grow_d;
  logic             sv_q, sv_d;
  logic [WIDTH-1:0] sd_q, sd_d;
  logic [LEN_W-1:0] si_q, si_d;
  logic             sl_q, sl_d;
  logic             last_seg;

  assign phase_d  = (phase_q == PH_MAX) ? '0 : phase_q + PH_W'(1);
  assign head_m1  = (head_q == '0) ? PH_MAX : head_q - PH_W'(1);
  assign last_seg = (cnt_q == len_q - LEN_W'(1));

  assign full      = (len_q == LEN_MAX);
  assign length    = len_q;
  assign busy      = (state_q != S_IDLE);
  assign seg_valid = sv_q;
  assign seg_dir   = sd_q;
  assign seg_idx   = si_q;
  assign seg_last  = sl_q;

  always_comb begin
    state_d    = state_q;
    head_d     = head_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    dir_d      = dir_q;
    grow_d     = grow_q;
    sv_d       = 1'b0;
    sd_d       = sd_q;
    si_d       = si_q;
    sl_d       = 1'b0;
    sr_in      = sr_out;
    step_ready = 1'b0;
    scan_ready = 1'b0;
    step_done  = 1'b0;
    unique case (state_q)
      S_INIT: begin
        sr_in = DIR_RST;
        if (phase_q == PH_MAX) state_d = S_IDLE;
      end
      S_IDLE: begin
        step_ready = 1'b1;
        scan_ready = 1'b1;
        if (step_valid) begin
          dir_d   = step_dir;
          grow_d  = step_grow;
          state_d = S_WSTEP;
        end else if (scan_valid) begin
          cnt_d   = '0;
          state_d = S_WSCAN;
        end
      end
      S_WSTEP: begin
        // new head goes into the slot just ahead of the current head
        if (phase_q == head_m1) begin
          sr_in  = dir_q;
          head_d = head_m1;
          if (grow_q && !full) len_d = len_q + LEN_W'(1);
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        step_done = 1'b1;
        state_d   = S_IDLE;
      end
      S_WSCAN, S_SCAN: begin
        if (state_q == S_SCAN || phase_q == head_q) begin
          sv_d    = 1'b1;
          sd_d    = sr_out;
          si_d    = cnt_q;
          sl_d    = last_seg;
          cnt_d   = cnt_q + LEN_W'(1);
          state_d = last_seg ? S_IDLE : S_SCAN;
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_INIT;
      phase_q <= '0;
      head_q  <= '0;
      len_q   <= LEN_RST;
      cnt_q   <= '0;
      dir_q   <= '0;
      grow_q  <= 1'b0;
      sv_q    <= 1'b0;
      sd_q    <= '0;
      si_q    <= '0;
      sl_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      head_q  <= head_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      grow_q  <= grow_d;
      sv_q    <= sv_d;
      sd_q    <= sd_d;
      si_q    <= si_d;
      sl_q    <= sl_d;
    end
  end

endmodule
